// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline register: datapath width, control FSM
// encoding, ALU operation classes and the per-edge action selected by the stage.
package id_ex_stage_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int CNT_W        = 16;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_t;

  // Highest-priority action wins on each edge.
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'b00,
    ACT_BUBBLE = 2'b01,
    ACT_HOLD   = 2'b10,
    ACT_FLUSH  = 2'b11
  } action_t;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard term: a load in EX whose destination is a
// non-zero register actually read by the instruction waiting in ID.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  output logic       hazard
);

  assign hazard = ex_valid && ex_memread && (ex_rd != 5'd0) && id_valid &&
                  ((id_rs1_used && (id_rs1 == ex_rd)) ||
                   (id_rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and saturating bubble/flush event counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rdata1,
  input  logic [XLEN-1:0] id_rdata2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            id_alusrc,
  input  logic            id_branch,
  input  logic [1:0]      id_aluop,
  input  logic            ex_branch_taken,
  input  logic            mem_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rdata1,
  output logic [XLEN-1:0] ex_rdata2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            ex_alusrc,
  output logic            ex_branch,
  output logic [1:0]      ex_aluop,
  output logic            pc_write,
  output logic            if_id_write,
  output logic            load_use_stall,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t  state;
  action_t act;
  ctrl_t   id_ctrl;
  ctrl_t   ex_ctrl;
  logic    hazard;

  assign id_ctrl = '{regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite,
                     memtoreg: id_memtoreg, alusrc: id_alusrc, branch: id_branch,
                     aluop: id_aluop};

  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_branch   = ex_ctrl.branch;
  assign ex_aluop    = ex_ctrl.aluop;

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_valid),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .hazard      (hazard)
  );

  // NOTE: every path assigns act, so this always_comb cannot infer a latch.
  always_comb begin
    act = ACT_LOAD;
    if (ex_branch_taken)  act = ACT_FLUSH;
    else if (mem_stall)   act = ACT_HOLD;
    else if (hazard)      act = ACT_BUBBLE;
  end

  assign load_use_stall = hazard && !ex_branch_taken;
  // Front end keeps advancing while in reset, whatever mem_stall says.
  assign pc_write    = !rst_n || !((act == ACT_HOLD) || (act == ACT_BUBBLE));
  assign if_id_write = pc_write;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rdata1  <= '0;
      ex_rdata2  <= '0;
      ex_imm     <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      case (state)
        ST_RUN:    if (act == ACT_BUBBLE) state <= ST_BUBBLE;
        ST_BUBBLE: if (act != ACT_HOLD)   state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase

      case (act)
        ACT_FLUSH: begin
          ex_valid  <= 1'b0;
          ex_ctrl   <= '0;
          flush_cnt <= sat_inc(flush_cnt);
        end
        ACT_HOLD: ;
        ACT_BUBBLE: begin
          ex_valid   <= 1'b0;
          ex_ctrl    <= '0;
          ex_rd      <= '0;
          bubble_cnt <= sat_inc(bubble_cnt);
        end
        default: begin
          ex_valid  <= id_valid;
          ex_pc     <= id_pc;
          ex_rdata1 <= id_rdata1;
          ex_rdata2 <= id_rdata2;
          ex_imm    <= id_imm;
          ex_rs1    <= id_rs1;
          ex_rs2    <= id_rs2;
          ex_rd     <= id_rd;
          ex_ctrl   <= id_valid ? id_ctrl : '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: a driver pushes hand-computed
// expectations into a queue, a monitor pops and compares once per cycle.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rdata1, id_rdata2, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_rs1_used, id_rs2_used;
  logic            id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch;
  logic [1:0]      id_aluop;
  logic            ex_branch_taken, mem_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic            ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch;
  logic [1:0]      ex_aluop;
  logic            pc_write, if_id_write, load_use_stall;
  logic [15:0]     bubble_cnt, flush_cnt;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_branch(id_branch),
    .id_aluop(id_aluop), .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
    .ex_aluop(ex_aluop), .pc_write(pc_write), .if_id_write(if_id_write),
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        lus;
    logic        pcw;
    logic        v;
    logic [31:0] pc;   // compared only when v is expected high
    int          rd;   // -1 means don't care
    logic        mr;
    logic        rw;
    logic [15:0] bc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Each step drives one cycle of ID inputs just after the rising edge. The
  // expectation covers this cycle's combinational outputs and the EX state
  // produced by the previous edge.
  task automatic step(
    input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
    input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic mr,
    input logic rw, input logic st, input logic br,
    input logic e_lus, input logic e_pcw, input logic e_v, input logic [31:0] e_pc,
    input int e_rd, input logic e_mr, input logic e_rw, input logic [15:0] e_bc,
    input logic [15:0] e_fc);
    exp_t e;
    @(posedge clk);
    #2;
    id_valid = v;  id_pc = pc;  id_rs1 = rs1;  id_rs1_used = u1;
    id_rs2 = rs2;  id_rs2_used = u2;  id_rd = rd;
    id_memread = mr;  id_regwrite = rw;  id_memtoreg = mr;
    mem_stall = st;  ex_branch_taken = br;
    step_no++;
    e.tag = $sformatf("s%0d", step_no);
    e.lus = e_lus;  e.pcw = e_pcw;  e.v = e_v;  e.pc = e_pc;  e.rd = e_rd;
    e.mr = e_mr;  e.rw = e_rw;  e.bc = e_bc;  e.fc = e_fc;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, "_stall"}, 32'(load_use_stall), 32'(e.lus));
        check({e.tag, "_pc_write"}, 32'(pc_write), 32'(e.pcw));
        check({e.tag, "_if_id_write"}, 32'(if_id_write), 32'(e.pcw));
        check({e.tag, "_ex_valid"}, 32'(ex_valid), 32'(e.v));
        if (e.v) check({e.tag, "_ex_pc"}, ex_pc, e.pc);
        if (e.rd >= 0) check({e.tag, "_ex_rd"}, 32'(ex_rd), 32'(e.rd));
        check({e.tag, "_ex_memread"}, 32'(ex_memread), 32'(e.mr));
        check({e.tag, "_ex_regwrite"}, 32'(ex_regwrite), 32'(e.rw));
        check({e.tag, "_bubble_cnt"}, 32'(bubble_cnt), 32'(e.bc));
        check({e.tag, "_flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic found;
    rst_n = 1'b0;
    id_valid = 1'b0;  id_pc = '0;  id_rs1 = '0;  id_rs2 = '0;  id_rd = '0;
    id_rs1_used = 1'b0;  id_rs2_used = 1'b0;
    id_regwrite = 1'b0;  id_memread = 1'b0;  id_memwrite = 1'b0;  id_memtoreg = 1'b0;
    id_alusrc = 1'b0;  id_branch = 1'b0;  id_aluop = ALUOP_FUNCT;
    id_rdata1 = 32'h1111_0000;  id_rdata2 = 32'h2222_0000;  id_imm = 32'h0000_0040;
    ex_branch_taken = 1'b0;  mem_stall = 1'b1;

    #3;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_pc_write", 32'(pc_write), 32'd1);
    check("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    mem_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    //    v  pc       rs1 u1 rs2 u2 rd  mr rw st br | lus pcw v  pc       rd  mr rw bc  fc
    // lw x5 followed by dependent add x6,x5,x7: one bubble, add enters EX two cycles after lw
    step(1, 32'h010, 1, 1, 0, 0, 5,  1, 1, 0, 0,   0, 1, 0, 32'h000, 0,  0, 0, 0, 0);
    step(1, 32'h014, 5, 1, 7, 1, 6,  0, 1, 0, 0,   1, 0, 1, 32'h010, 5,  1, 1, 0, 0);
    step(1, 32'h014, 5, 1, 7, 1, 6,  0, 1, 0, 0,   0, 1, 0, 32'h000, 0,  0, 0, 1, 0);
    step(1, 32'h018, 1, 1, 2, 1, 7,  0, 1, 0, 0,   0, 1, 1, 32'h014, 6,  0, 1, 1, 0);
    // load to x0 never stalls
    step(1, 32'h020, 1, 1, 0, 0, 0,  1, 1, 0, 0,   0, 1, 1, 32'h018, 7,  0, 1, 1, 0);
    step(1, 32'h024, 0, 1, 0, 1, 8,  0, 1, 0, 0,   0, 1, 1, 32'h020, 0,  1, 1, 1, 0);
    // rs2 matches the load but is not read
    step(1, 32'h028, 1, 1, 0, 0, 5,  1, 1, 0, 0,   0, 1, 1, 32'h024, 8,  0, 1, 1, 0);
    step(1, 32'h02c, 3, 1, 5, 0, 9,  0, 1, 0, 0,   0, 1, 1, 32'h028, 5,  1, 1, 1, 0);
    // hazard and branch-taken in the same cycle: flush wins
    step(1, 32'h030, 1, 1, 0, 0, 5,  1, 1, 0, 0,   0, 1, 1, 32'h02c, 9,  0, 1, 1, 0);
    step(1, 32'h034, 5, 1, 0, 0, 10, 0, 1, 0, 1,   0, 1, 1, 32'h030, 5,  1, 1, 1, 0);
    step(1, 32'h040, 0, 0, 0, 0, 11, 0, 1, 0, 0,   0, 1, 0, 32'h000, -1, 0, 0, 1, 1);
    // three-cycle downstream hold with 0x100 in EX
    step(1, 32'h100, 0, 0, 0, 0, 12, 0, 1, 0, 0,   0, 1, 1, 32'h040, 11, 0, 1, 1, 1);
    step(1, 32'h104, 0, 0, 0, 0, 13, 0, 1, 1, 0,   0, 0, 1, 32'h100, 12, 0, 1, 1, 1);
    step(1, 32'h104, 0, 0, 0, 0, 13, 0, 1, 1, 0,   0, 0, 1, 32'h100, 12, 0, 1, 1, 1);
    step(1, 32'h104, 0, 0, 0, 0, 13, 0, 1, 1, 0,   0, 0, 1, 32'h100, 12, 0, 1, 1, 1);
    step(1, 32'h104, 0, 0, 0, 0, 13, 0, 1, 0, 0,   0, 1, 1, 32'h100, 12, 0, 1, 1, 1);
    // invalid instruction loads with controls cleared
    step(0, 32'h108, 0, 0, 0, 0, 14, 1, 1, 0, 0,   0, 1, 1, 32'h104, 13, 0, 1, 1, 1);
    step(1, 32'h10c, 0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 1, 0, 32'h000, 14, 0, 0, 1, 1);

    // Saturation: preload the counter near its ceiling to keep the run short,
    // then hold "lw x5,0(x5)" in ID, which bubbles every second cycle.
    @(posedge clk);
    #2;
    id_valid = 1'b1;  id_pc = 32'h200;  id_rs1 = 5'd5;  id_rs1_used = 1'b1;
    id_rs2_used = 1'b0;  id_rd = 5'd5;  id_memread = 1'b1;  id_regwrite = 1'b1;
    force dut.bubble_cnt = 16'hFFFA;
    #1;
    release dut.bubble_cnt;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("bubble_cnt_saturated", 32'(bubble_cnt), 32'h0000_FFFF);

    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (load_use_stall) found = 1'b1;
    end
    check("stall_before_reset", 32'(found), 32'd1);

    // Now in BUBBLE with a hold pending; reset must clear everything at once.
    @(posedge clk);
    #2;
    mem_stall = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_rst_ex_valid", 32'(ex_valid), 32'd0);
    check("async_rst_ex_pc", ex_pc, 32'd0);
    check("async_rst_ex_rd", 32'(ex_rd), 32'd0);
    check("async_rst_ex_memread", 32'(ex_memread), 32'd0);
    check("async_rst_ex_regwrite", 32'(ex_regwrite), 32'd0);
    check("async_rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("async_rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("async_rst_pc_write", 32'(pc_write), 32'd1);
    check("async_rst_if_id_write", 32'(if_id_write), 32'd1);

    id_pc = 32'h300;  id_rs1 = 5'd0;  id_rs1_used = 1'b0;  id_rd = 5'd20;
    id_memread = 1'b0;  id_regwrite = 1'b1;  mem_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ex_valid", 32'(ex_valid), 32'd1);
    check("post_rst_ex_pc", ex_pc, 32'h300);
    check("post_rst_ex_rd", 32'(ex_rd), 32'd20);
    check("post_rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
